i2c_slave_regs: RTL and testbench
=================================

I2C_SLAVE_REGS -- requirements
Module: i2c_slave_regs

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50, the 7-bit device address matched after START.
REQ-002 SHALL have parameter NUM_REGS, default 16, the number of 8-bit registers in the internal register file (2..256).
REQ-003 SHALL have parameter REG_ADDR_W, default 4, the register pointer width; SHALL satisfy 2**REG_ADDR_W >= NUM_REGS.
REQ-004 SHALL have parameter SYNC_STAGES, default 2, the synchroniser depth for scl/sda inputs (>=2).
REQ-005 clk  input  1  system clock; all logic on the rising edge; must be >=8x the scl rate.
REQ-006 rst  input  1  reset, synchronous and active-low.
REQ-007 scl  input  1  I2C clock from the master.
REQ-008 sda  inout  1  I2C data, open-drain: driven 0 or released (z), never driven 1.
REQ-009 wr_valid  output  1  one-clk pulse when a register is written from the bus.
REQ-010 wr_addr  output  REG_ADDR_W  register index of the write; valid with wr_valid.
REQ-011 wr_data  output  8  byte written; valid with wr_valid.
REQ-012 busy  output  1  high from an addressed START (address match) until STOP.

Function
REQ-013 scl and sda SHALL each pass through SYNC_STAGES flops; edge detection SHALL use the synchronised values only.
REQ-014 START = synced sda falling while synced scl high; STOP = synced sda rising while synced scl high; both SHALL be detected in any state.
REQ-015 Bits SHALL be sampled on synced scl rising edge, MSB first; the slave SHALL change sda drive only on synced scl falling edge.
REQ-016 FSM states: IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
REQ-017 IDLE->DEV_ADDR on START; after 8 bits, if addr[7:1]==SLAVE_ADDR -> DEV_ACK (drive 0 for the 9th bit), else -> IDLE with sda released.
REQ-018 After DEV_ACK: R/W=0 -> REG_ADDR; R/W=1 -> RD_DATA, transmitting reg[pointer].
REQ-019 REG_ADDR byte < NUM_REGS SHALL load the pointer and be ACKed (REG_ACK -> WR_DATA); byte >= NUM_REGS SHALL be NACKed (sda released) and FSM -> IDLE, pointer unchanged.
REQ-020 Each WR_DATA byte SHALL be ACKed, written to reg[pointer], and pulse wr_valid for exactly one clk on the 8th sampled bit; wr_addr = pointer before any increment.
REQ-021 In RD_ACK, master ACK (sda=0) -> next byte in RD_DATA; master NACK -> IDLE with sda released.
REQ-022 Repeated START in any state SHALL return to DEV_ADDR keeping the pointer (enables write-pointer-then-read).
REQ-023 STOP in any state SHALL -> IDLE, release sda, drop busy on the next clk; a partially received byte SHALL be discarded (no write).
REQ-024 Pointer wrap: after index NUM_REGS-1 the next index SHALL be 0.
REQ-025 Read data SHALL be the register value at the start of the byte (bus write and read cannot overlap).

Reset
REQ-026 While rst=0 at a clk edge: FSM=IDLE, sda released, wr_valid=0, wr_addr=0, wr_data=0, busy=0, pointer=0, all registers=8'h00, synchronisers=1.
REQ-027 Reset mid-transfer SHALL abort immediately; the slave SHALL ignore the bus until the next START.

Configuration
REQ-028 With I2C_AUTOINC_EN defined, the pointer SHALL increment (with wrap) after every data byte written or read.
REQ-029 Without I2C_AUTOINC_EN, the pointer SHALL stay fixed; multi-byte writes overwrite the same register, reads repeat it.

Structure
REQ-030 A shared package i2c_pkg SHALL hold the FSM state enum, the ACK/NACK constants and the R/W bit encodings.
REQ-031 Sub-module i2c_sync_edge SHALL implement the synchroniser plus rise/fall detection, instantiated once each for scl and sda.

Verification
REQ-032 Write: START, 0xA0, 0x03, 0x5A, STOP -> three ACKs, wr_valid once with wr_addr=3, wr_data=0x5A; reg3=0x5A.
REQ-033 Random read: START 0xA0 0x03, repeated START 0xA1, master NACK -> slave drives 0x5A; busy falls after STOP.
REQ-034 Burst with I2C_AUTOINC_EN, NUM_REGS=16: write 0x11,0x22 from pointer 15 -> reg15=0x11, reg0=0x22 (wrap).
REQ-035 Address 0xA2 (mismatch) -> sda never driven low, busy stays 0, no wr_valid.
REQ-036 Register address 0x20 with NUM_REGS=16 -> NACK, FSM IDLE, pointer unchanged.
REQ-037 STOP after 4 bits of a data byte, then rst=0 mid-byte on a second transfer -> no write, all outputs at reset values.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register slave: FSM states, ACK levels, R/W bit encodings.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEV_ADDR,
    DEV_ACK,
    REG_ADDR,
    REG_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK
  } state_t;

  localparam logic ACK      = 1'b0;
  localparam logic NACK     = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchroniser for an asynchronous bus line, with rise/fall strobes on the synced value.
module i2c_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      chain <= '1;
      prev  <= 1'b1;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C slave exposing an 8-bit register file with a pointer register.
// Define I2C_AUTOINC_EN to advance the pointer (with wrap) after every data byte.
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned REG_ADDR_W  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl,
  inout  logic                  sda,
  output logic                  wr_valid,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [7:0]            wr_data,
  output logic                  busy
);

  logic scl_q, scl_rise, scl_fall;
  logic sda_q, sda_rise, sda_fall;

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk(clk), .rst(rst), .d(scl), .q(scl_q), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk(clk), .rst(rst), .d(sda), .q(sda_q), .rise(sda_rise), .fall(sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = sda_fall & scl_q;
  assign stop_det  = sda_rise & scl_q;

  state_t                state, state_n;
  logic [3:0]            cnt, cnt_n;
  logic [6:0]            shreg, shreg_n;
  logic [6:0]            tx, tx_n;
  logic [REG_ADDR_W-1:0] ptr, ptr_n, ptr_adv;
  logic                  sda_low, sda_low_n;
  logic                  busy_n;
  logic                  phase, phase_n;
  logic                  we, wvalid_n;
  logic [7:0]            byte_in, rd_byte;
  logic [7:0]            regs [NUM_REGS];

  assign sda     = sda_low ? 1'b0 : 1'bz;
  assign byte_in = {shreg, sda_q};
  assign rd_byte = regs[ptr];

`ifdef I2C_AUTOINC_EN
  assign ptr_adv = (ptr == REG_ADDR_W'(NUM_REGS - 1)) ? '0 : ptr + 1'b1;
`else
  assign ptr_adv = ptr;
`endif

  // ACK states take two scl falls: the first starts the drive, the second ends the 9th bit.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shreg_n   = shreg;
    tx_n      = tx;
    ptr_n     = ptr;
    sda_low_n = sda_low;
    busy_n    = busy;
    phase_n   = phase;
    we        = 1'b0;
    wvalid_n  = 1'b0;

    if (stop_det) begin
      state_n   = IDLE;
      sda_low_n = 1'b0;
      busy_n    = 1'b0;
    end else if (start_det) begin
      state_n   = DEV_ADDR;
      cnt_n     = '0;
      sda_low_n = 1'b0;
      phase_n   = 1'b0;
    end else begin
      unique case (state)
        IDLE: ;

        DEV_ADDR, REG_ADDR, WR_DATA: begin
          if (scl_rise) begin
            shreg_n = byte_in[6:0];
            cnt_n   = cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt_n   = '0;
              phase_n = 1'b0;
              if (state == DEV_ADDR) begin
                if (byte_in[7:1] == SLAVE_ADDR) begin
                  state_n = DEV_ACK;
                  busy_n  = 1'b1;
                end else begin
                  state_n = IDLE;
                end
              end else if (state == REG_ADDR) begin
                if ({1'b0, byte_in} < 9'(NUM_REGS)) begin
                  ptr_n   = byte_in[REG_ADDR_W-1:0];
                  state_n = REG_ACK;
                end else begin
                  state_n = IDLE;
                end
              end else begin
                we       = 1'b1;
                wvalid_n = 1'b1;
                ptr_n    = ptr_adv;
                state_n  = WR_ACK;
              end
            end
          end
        end

        DEV_ACK, REG_ACK, WR_ACK: begin
          if (scl_fall) begin
            if (!phase) begin
              sda_low_n = ~ACK;
              phase_n   = 1'b1;
            end else begin
              phase_n = 1'b0;
              cnt_n   = '0;
              if (state == DEV_ACK && shreg[0] == RW_READ) begin
                state_n   = RD_DATA;
                tx_n      = rd_byte[6:0];
                sda_low_n = ~rd_byte[7];
              end else begin
                state_n   = (state == DEV_ACK) ? REG_ADDR : WR_DATA;
                sda_low_n = 1'b0;
              end
            end
          end
        end

        RD_DATA: begin
          if (scl_rise) begin
            cnt_n = cnt + 4'd1;
          end else if (scl_fall) begin
            if (cnt == 4'd8) begin
              sda_low_n = 1'b0;
              state_n   = RD_ACK;
              cnt_n     = '0;
              phase_n   = 1'b0;
              ptr_n     = ptr_adv;
            end else begin
              sda_low_n = ~tx[6];
              tx_n      = {tx[5:0], 1'b0};
            end
          end
        end

        RD_ACK: begin
          if (scl_rise) begin
            if (sda_q == NACK) state_n = IDLE;
            else               phase_n = 1'b1;
          end else if (scl_fall && phase) begin
            state_n   = RD_DATA;
            phase_n   = 1'b0;
            tx_n      = rd_byte[6:0];
            sda_low_n = ~rd_byte[7];
          end
        end

        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      tx       <= '0;
      ptr      <= '0;
      sda_low  <= 1'b0;
      busy     <= 1'b0;
      phase    <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      shreg    <= shreg_n;
      tx       <= tx_n;
      ptr      <= ptr_n;
      sda_low  <= sda_low_n;
      busy     <= busy_n;
      phase    <= phase_n;
      wr_valid <= wvalid_n;
      if (we) begin
        regs[ptr] <= byte_in;
        wr_addr   <= ptr;
        wr_data   <= byte_in;
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed self-checking bench for i2c_slave_regs; expectations follow I2C_AUTOINC_EN when defined.
module tb_i2c_slave_regs;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  wire        sda;
  logic       wr_valid;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_slave_regs #(
    .SLAVE_ADDR(7'h50), .NUM_REGS(16), .REG_ADDR_W(4), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int slave_low = 0;
  logic [3:0] wr_addr_log [$];

  always @(negedge clk) begin
    if (wr_valid === 1'b1) begin
      wr_cnt++;
      wr_addr_log.push_back(wr_addr);
    end
    if (sda === 1'b0 && !m_low) slave_low++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_low = 1'b1; wait_q();
    scl = 1'b0;   wait_q();
  endtask

  task automatic i2c_rstart();
    m_low = 1'b0; wait_q();
    scl = 1'b1;   wait_q();
    m_low = 1'b1; wait_q();
    scl = 1'b0;   wait_q();
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; wait_q();
    scl = 1'b1;   wait_q();
    m_low = 1'b0; wait_q();
    wait_q();
  endtask

  task automatic send_bit(input logic b);
    m_low = ~b; wait_q();
    scl = 1'b1; wait_q();
    wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic recv_bit(output logic b);
    m_low = 1'b0; wait_q();
    scl = 1'b1;   wait_q();
    b = sda;      wait_q();
    scl = 1'b0;   wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  // Set pointer, repeated START, read n (1 or 2) bytes, NACK the last, STOP.
  task automatic rand_read(input logic [7:0] r, input int n, output logic [7:0] b0, output logic [7:0] b1);
    logic a;
    b1 = '0;
    i2c_start();
    write_byte(8'hA0, a); chk("rr_dev_ack", a, 0);
    write_byte(r, a);     chk("rr_reg_ack", a, 0);
    i2c_rstart();
    write_byte(8'hA1, a); chk("rr_rdev_ack", a, 0);
    read_byte(b0, n == 1);
    if (n > 1) read_byte(b1, 1'b1);
    chk("rr_busy_before_stop", busy, 1);
    i2c_stop();
    chk("rr_busy_after_stop", busy, 0);
  endtask

  typedef struct {
    logic [7:0] dev;
    logic [7:0] reg_a;
    logic [7:0] data;
    logic       dack;
    logic       rack;
    logic       wack;
    logic       wr;
  } wvec_t;

  wvec_t vec [5];

  initial begin
    logic       a;
    logic [7:0] b0, b1;
    logic [7:0] exp_cur, exp_b0, exp_b1, exp_r0;
    logic [3:0] exp_wa0, exp_wa1;
    int         w0;

`ifdef I2C_AUTOINC_EN
    exp_cur = 8'h00; exp_b0 = 8'h11; exp_b1 = 8'h22; exp_r0 = 8'h22;
    exp_wa0 = 4'd15; exp_wa1 = 4'd0;
`else
    exp_cur = 8'h3C; exp_b0 = 8'h22; exp_b1 = 8'h22; exp_r0 = 8'h00;
    exp_wa0 = 4'd15; exp_wa1 = 4'd15;
`endif

    vec[0] = '{8'hA0, 8'h03, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1};
    vec[1] = '{8'hA0, 8'h0F, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1};
    vec[2] = '{8'hA0, 8'h07, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1};
    vec[3] = '{8'hA2, 8'h05, 8'h77, 1'b1, 1'b1, 1'b1, 1'b0};
    vec[4] = '{8'hA0, 8'h20, 8'h99, 1'b0, 1'b1, 1'b1, 1'b0};

    repeat (5) @(negedge clk);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sda", sda, 1);
    rst = 1'b1;
    wait_q();

    for (int i = 0; i < 5; i++) begin
      w0 = wr_cnt;
      slave_low = 0;
      i2c_start();
      write_byte(vec[i].dev, a);   chk("v_dev_ack", a, vec[i].dack);
      chk("v_busy_on", busy, !vec[i].dack);
      write_byte(vec[i].reg_a, a); chk("v_reg_ack", a, vec[i].rack);
      write_byte(vec[i].data, a);  chk("v_data_ack", a, vec[i].wack);
      i2c_stop();
      chk("v_busy_off", busy, 0);
      chk("v_wr_count", wr_cnt - w0, vec[i].wr ? 1 : 0);
      if (vec[i].wr) begin
        chk("v_wr_addr", wr_addr, vec[i].reg_a[3:0]);
        chk("v_wr_data", wr_data, vec[i].data);
      end
      if (vec[i].dack) chk("v_slave_never_low", slave_low, 0);
    end

    // Pointer survives the out-of-range register address.
    i2c_start();
    write_byte(8'hA1, a); chk("cur_dev_ack", a, 0);
    read_byte(b0, 1'b1);
    i2c_stop();
    chk("cur_read_data", b0, exp_cur);

    rand_read(8'h03, 1, b0, b1);
    chk("rd_reg3", b0, 8'h5A);
    rand_read(8'h0F, 1, b0, b1);
    chk("rd_reg15", b0, 8'hC3);

    // Burst write starting at the last register.
    w0 = wr_cnt;
    wr_addr_log.delete();
    i2c_start();
    write_byte(8'hA0, a); chk("bw_dev_ack", a, 0);
    write_byte(8'h0F, a); chk("bw_reg_ack", a, 0);
    write_byte(8'h11, a); chk("bw_d0_ack", a, 0);
    write_byte(8'h22, a); chk("bw_d1_ack", a, 0);
    i2c_stop();
    chk("bw_wr_count", wr_cnt - w0, 2);
    if (wr_addr_log.size() == 2) begin
      chk("bw_wr_addr0", wr_addr_log[0], exp_wa0);
      chk("bw_wr_addr1", wr_addr_log[1], exp_wa1);
    end
    chk("bw_wr_data", wr_data, 8'h22);
    rand_read(8'h0F, 2, b0, b1);
    chk("br_byte0", b0, exp_b0);
    chk("br_byte1", b1, exp_b1);
    rand_read(8'h00, 1, b0, b1);
    chk("br_reg0", b0, exp_r0);

    // Partial byte cut by STOP must not write.
    w0 = wr_cnt;
    i2c_start();
    write_byte(8'hA0, a);
    write_byte(8'h03, a);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    i2c_stop();
    chk("stop_partial_no_write", wr_cnt - w0, 0);

    // Reset in the middle of a data byte.
    i2c_start();
    write_byte(8'hA0, a);
    write_byte(8'h03, a);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    m_low = 1'b0;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_rst_wr_valid", wr_valid, 0);
    chk("mid_rst_wr_addr", wr_addr, 0);
    chk("mid_rst_wr_data", wr_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sda", sda, 1);
    rst = 1'b1;
    wait_q();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    recv_bit(a);
    chk("post_rst_no_ack", a, 1);
    chk("post_rst_busy", busy, 0);
    i2c_stop();
    chk("rst_partial_no_write", wr_cnt - w0, 0);
    rand_read(8'h03, 1, b0, b1);
    chk("reg3_cleared_by_rst", b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
